// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared dtw constants and sink-reader FSM encoding
package dtw_pkg;

  // Output buffer depth; the issue credit never lets more words be outstanding.
  localparam int DTW_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } dtw_state_e;

endpackage

// File: rtl/dtw_skid_buf.sv
// rtl/dtw_skid_buf.sv - two-entry FIFO-order output buffer
module dtw_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign do_pop = pop && (count_q != 2'd0);
  assign count  = count_q;
  assign data   = mem_q[rd_ptr_q];

  // Ring of two entries; the caller's credit guarantees no push into a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dtw_sink_reader.sv
// rtl/dtw_sink_reader.sv - drains dtw_core result FIFO to a stream and tracks the minimum
module dtw_sink_reader
  import dtw_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int BUF_DEPTH = DTW_BUF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       result_count,
  output logic              fifo_rden,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] best_score,
  output logic [31:0]       best_index
);

  dtw_state_e        state_q, state_d;
  logic [31:0]       count_q;
  logic [31:0]       issued_q;
  logic [31:0]       cap_idx_q;
  logic              inflight_q;
  logic [DWIDTH-1:0] best_score_q;
  logic [31:0]       best_index_q;

  logic [1:0]        buf_count;
  logic [DWIDTH:0]   buf_data;
  logic              buf_push;
  logic              buf_pop;
  logic [2:0]        credit;
  logic              rden_ok;
  logic              start_acc;

  assign start_acc = start && (state_q == ST_IDLE);
  assign buf_push  = inflight_q;
  assign m_valid   = (buf_count != 2'd0);
  assign m_data    = buf_data[DWIDTH-1:0];
  assign m_last    = m_valid && buf_data[DWIDTH];
  assign buf_pop   = m_valid && m_ready;

  // The word leaving this cycle frees its slot, which keeps one word per cycle flowing.
  assign credit  = {2'b00, inflight_q} + {1'b0, buf_count} - {2'b00, buf_pop};
  assign rden_ok = (state_q == ST_RUN) && !rst && !fifo_empty &&
                   (issued_q < count_q) && (credit < 3'(BUF_DEPTH));

  assign best_score = best_score_q;
  assign best_index = best_index_q;

  dtw_skid_buf #(.WIDTH(DWIDTH + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data ({cap_idx_q == count_q - 32'd1, fifo_data}),
    .pop       (buf_pop),
    .count     (buf_count),
    .data      (buf_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (result_count == 32'd0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (issued_q == count_q) state_d = ST_FLUSH;
      ST_FLUSH: if (buf_pop && m_last) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control outputs decoded from state.
  always_comb begin
    fifo_rden = rden_ok;
    busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    done      = (state_q == ST_FIN);
  end

  // Word counters, in-flight read flag and minimum tracker; an in-flight word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      issued_q     <= '0;
      cap_idx_q    <= '0;
      inflight_q   <= 1'b0;
      best_score_q <= '1;
      best_index_q <= '0;
    end else begin
      inflight_q <= rden_ok;
      if (start_acc) begin
        count_q      <= result_count;
        issued_q     <= '0;
        cap_idx_q    <= '0;
        best_score_q <= '1;
        best_index_q <= '0;
      end else begin
        if (rden_ok) issued_q <= issued_q + 32'd1;
        if (buf_push) begin
          cap_idx_q <= cap_idx_q + 32'd1;
          if (fifo_data < best_score_q) begin
            best_score_q <= fifo_data;
            best_index_q <= cap_idx_q;
          end
        end
      end
    end
  end

endmodule
